// File: rtl/alu_acc_sequencer_pkg.sv
// alu_acc_sequencer_pkg: op codes, FSM states and ALU select constants shared by the sequencer.
package alu_acc_sequencer_pkg;
   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_INC  = 3'd3,
      OP_CMP  = 3'd4,
      OP_MUL  = 3'd5
   } op_t;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2
   } state_t;
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_INC  = 2'b10;
   localparam logic [1:0] ALU_PASS = 2'b11;
   function automatic logic [1:0] op_sel(input logic [2:0] op);
      return op == OP_ADD ? ALU_ADD :
             (op == OP_SUB || op == OP_CMP) ? ALU_SUB :
             op == OP_INC ? ALU_INC : ALU_PASS;
   endfunction
endpackage

// File: rtl/alu_acc_sequencer_mul_step.sv
// alu_mul_step: shift-add multiply state; the add itself happens in the external ALU.
module alu_mul_step #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] mplier,
   input  logic [WIDTH-1:0] mcand_in,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] p_hi,
   output logic [WIDTH-1:0] p_lo,
   output logic [WIDTH-1:0] mcand,
   output logic [WIDTH-1:0] hi_nx,
   output logic [WIDTH-1:0] lo_nx,
   output logic             last
);
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0] cnt;
   // The ALU carry becomes the top bit so the 9-bit partial sum survives the shift.
   assign hi_nx = {alu_cout, alu_out[WIDTH-1:1]};
   assign lo_nx = {alu_out[0], p_lo[WIDTH-1:1]};
   assign last  = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_hi  <= '0;
         p_lo  <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (start) begin
         p_hi  <= '0;
         p_lo  <= mplier;
         mcand <= mcand_in;
         cnt   <= '0;
      end else if (step) begin
         p_hi <= hi_nx;
         p_lo <= lo_nx;
         cnt  <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: command sequencer, accumulator and flags wrapped around an external 8-bit ALU.
module alu_acc_sequencer
   import alu_acc_sequencer_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             done,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] res_hi,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_z,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_s,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cout,
   input  logic             alu_neg,
   input  logic             alu_ovf
);
   state_t           state, state_nx;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] p_hi, p_lo, mcand, hi_nx, lo_nx;
   logic             accept, is_mul, mul_last, exec_wr, is_load;
   assign cmd_ready = state == S_IDLE;
   assign accept    = cmd_valid & cmd_ready;
   assign is_mul    = MUL_EN && cmd_op == OP_MUL;
   assign is_load   = op_q == OP_LOAD;
   assign exec_wr   = op_q inside {OP_LOAD, OP_ADD, OP_SUB, OP_INC, OP_CMP};
   alu_mul_step #(.WIDTH(WIDTH)) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept & is_mul),
      .step     (state == S_MUL),
      .mplier   (cmd_data),
      .mcand_in (acc),
      .alu_out  (alu_out),
      .alu_cout (alu_cout),
      .p_hi     (p_hi),
      .p_lo     (p_lo),
      .mcand    (mcand),
      .hi_nx    (hi_nx),
      .lo_nx    (lo_nx),
      .last     (mul_last)
   );
   always_comb begin
      state_nx = state == S_IDLE ? (accept ? (is_mul ? S_MUL : S_EXEC) : S_IDLE) :
                 (state == S_MUL && !mul_last) ? S_MUL : S_IDLE;
      alu_a = state == S_MUL ? p_hi : (state == S_EXEC && is_load) ? opnd_q : acc;
      alu_b = state == S_MUL ? mcand : state == S_EXEC ? opnd_q : '0;
      alu_s = state == S_MUL ? (p_lo[0] ? ALU_ADD : ALU_PASS) :
              state == S_EXEC ? op_sel(op_q) : ALU_PASS;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= '0;
         opnd_q <= '0;
         done   <= 1'b0;
         acc    <= '0;
         res_hi <= '0;
         flag_c <= 1'b0;
         flag_n <= 1'b0;
         flag_v <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= state == S_EXEC || (state == S_MUL && mul_last);
         if (accept) begin
            op_q   <= cmd_op;
            opnd_q <= cmd_data;
         end
         // Reserved ops fall through EXEC untouched apart from the done pulse.
         if (state == S_EXEC && exec_wr) begin
            flag_c <= is_load ? 1'b0 : alu_cout;
            flag_v <= is_load ? 1'b0 : alu_ovf;
            flag_n <= alu_neg;
            flag_z <= alu_out == '0;
            if (op_q != OP_CMP) acc <= alu_out;
         end
         if (state == S_MUL && mul_last) begin
            acc    <= lo_nx;
            res_hi <= hi_nx;
            flag_c <= |hi_nx;
            flag_v <= |hi_nx;
            flag_n <= lo_nx[WIDTH-1];
            flag_z <= lo_nx == '0;
         end
      end
   end
endmodule
